// File: rtl/pipe_stage_reg_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding, EX/MEM control bit map, default widths
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } pipe_state_t;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ZERO     = 5;
  localparam int CTRL_RD_LSB   = 6;
  localparam int CTRL_RD_W     = 5;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 12;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// pipe_stage_reg_if : valid/ready handshake carrying payload and control
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg_stats.sv
// ============================================================================
// pipe_stage_stats : saturating stall / flush event counters
// Revision         : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    // out_valid covers "any entry held": S is never occupied while M is empty
    if (flush && out_valid && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : elastic pipeline stage register, optional 2-entry skid
// Optional stall/flush counters when PIPE_STAGE_STATS_EN is defined.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
`ifdef PIPE_STAGE_STATS_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
`endif
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if
);

  pipe_state_t       state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic in_ready;
  logic in_fire;
  logic out_fire;

  assign in_fire  = in_if.valid & in_ready;
  assign out_fire = out_valid_q & out_if.ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (SKID != 0) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_data_d = in_if.data;
            m_ctrl_d = in_if.ctrl;
            state_d  = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            m_data_d = in_if.data;
            m_ctrl_d = in_if.ctrl;
          end else if (in_fire) begin
            s_data_d = in_if.data;
            s_ctrl_d = in_if.ctrl;
            state_d  = pipe_pkg::SKID;
          end else if (out_fire) begin
            m_ctrl_d = '0;
            state_d  = EMPTY;
          end
        end
        pipe_pkg::SKID: begin
          if (out_fire) begin
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_ctrl_d = '0;
            state_d  = FULL;
          end
        end
        default: begin
          m_ctrl_d = '0;
          s_ctrl_d = '0;
          state_d  = EMPTY;
        end
      endcase
    end else begin
      if (in_fire) begin
        m_data_d = in_if.data;
        m_ctrl_d = in_if.ctrl;
        state_d  = FULL;
      end else if (out_fire) begin
        m_ctrl_d = '0;
        state_d  = EMPTY;
      end
    end

    // Flush wins: a coinciding in_fire is dropped, payload stays for debug
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end
  end

  assign out_valid_d = (state_d != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_ready
      logic in_ready_q, in_ready_d;

      assign in_ready_d = (state_d != pipe_pkg::SKID);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
      end

      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = out_if.ready | ~out_valid_q;
    end
  endgenerate

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = m_data_q;
  assign out_if.ctrl  = m_ctrl_q;

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_valid (out_valid_q),
    .out_ready (out_if.ready),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : scoreboard bench driving a SKID=0 and a SKID=1 stage
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 12;
  localparam int EW = DW + CW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) in0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) out0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) in1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) out1 ();

  assign in0.valid  = in_valid;
  assign in0.data   = in_data;
  assign in0.ctrl   = in_ctrl;
  assign in1.valid  = in_valid;
  assign in1.data   = in_data;
  assign in1.ctrl   = in_ctrl;
  assign out0.ready = out_ready;
  assign out1.ready = out_ready;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt [2];
  logic [15:0] flush_cnt [2];
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt (stall_cnt[0]),
    .flush_cnt (flush_cnt[0]),
`endif
    .in_if     (in0),
    .out_if    (out0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt (stall_cnt[1]),
    .flush_cnt (flush_cnt[1]),
`endif
    .in_if     (in1),
    .out_if    (out1)
  );

  logic [1:0]    ir, ov;
  logic [DW-1:0] od [2];
  logic [CW-1:0] oc [2];
  assign ir    = {in1.ready, in0.ready};
  assign ov    = {out1.valid, out0.valid};
  assign od[0] = out0.data;
  assign od[1] = out1.data;
  assign oc[0] = out0.ctrl;
  assign oc[1] = out1.ctrl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-stage FIFO of accepted entries, capacity 1 or 2
  logic [EW-1:0] mem [2][2];
  int            mcnt [2];
  int            cnt_start [2];
  int            mstall [2];
  int            mflush [2];
  bit            chk_en;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input int k,
                     input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  // Monitor: compares whatever the stages present, pops on each out handshake
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        cnt_start[k] = mcnt[k];
        chk("out_valid", k, ov[k], mcnt[k] > 0);
        if (mcnt[k] > 0) begin
          chk("out_data", k, od[k], mem[k][0][EW-1:CW]);
          chk("out_ctrl", k, oc[k], mem[k][0][CW-1:0]);
          if (out_ready) begin
            mem[k][0] = mem[k][1];
            mcnt[k]   = mcnt[k] - 1;
          end
        end else begin
          chk("bubble_ctrl", k, oc[k], 0);
        end
      end
    end
  end

  task automatic step(input bit iv, input bit ordy, input bit fl,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit exp_ir;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    in_ctrl   = c;
    #3;
    for (int k = 0; k < 2; k++) begin
      exp_ir = (k == 1) ? (cnt_start[k] < 2) : ((cnt_start[k] == 0) || ordy);
      chk("in_ready", k, ir[k], exp_ir);
      if (cnt_start[k] > 0 && !ordy && mstall[k] < 65535) mstall[k]++;
      if (cnt_start[k] > 0 && fl && mflush[k] < 65535) mflush[k]++;
      if (fl) begin
        mcnt[k] = 0;
      end else if (iv && exp_ir) begin
        mem[k][mcnt[k]] = {d, c};
        mcnt[k]         = mcnt[k] + 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    chk_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, ov[k], 0);
      chk("rst_out_ctrl", k, oc[k], 0);
      mcnt[k]      = 0;
      cnt_start[k] = 0;
      mstall[k]    = 0;
      mflush[k]    = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  logic [DW-1:0] rd;
  logic [CW-1:0] rc;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; cnt_start[k] = 0; mstall[k] = 0; mflush[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, ov[k], 0);
      chk("reset_data", k, od[k], 0);
      chk("reset_ctrl", k, oc[k], 0);
    end
    chk("reset_in_ready", 1, ir[1], 1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Streaming 0x1..0x8 with downstream always ready
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, DW'(i), CW'(i));
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);

    // Backpressure: A then B stalled, then drained in order
    step(1'b1, 1'b0, 1'b0, DW'(32'hA), 12'h0A1);
    step(1'b1, 1'b0, 1'b0, DW'(32'hB), 12'h0B2);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    chk("bp_in_ready", 1, ir[1], 0);
    chk("bp_head", 1, od[1], DW'(32'hA));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, '0);

    // Flush while SKID is full, colliding with a new entry C
    step(1'b1, 1'b0, 1'b0, DW'(32'hA), 12'h03F);
    step(1'b1, 1'b0, 1'b0, DW'(32'hB), 12'h03F);
    step(1'b1, 1'b0, 1'b1, DW'(32'hC), 12'h03F);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);

    // SKID=0: stalled then released in the same cycle as a new push
    step(1'b1, 1'b0, 1'b0, DW'(32'hD), 12'h123);
    step(1'b1, 1'b0, 1'b0, DW'(32'hE), 12'h456);
    step(1'b1, 1'b1, 1'b0, DW'(32'hE), 12'h456);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);

    // Reset with both skid entries occupied
    step(1'b1, 1'b0, 1'b0, DW'(32'h11), 12'hFFF);
    step(1'b1, 1'b0, 1'b0, DW'(32'h22), 12'hFFF);
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 2000; i++) begin
      rd = {$urandom, $urandom, $urandom};
      rc = CW'($urandom);
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0), rd, rc);
    end
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);

`ifdef PIPE_STAGE_STATS_EN
    do_reset();
    step(1'b1, 1'b0, 1'b0, DW'(32'h77), 12'h001);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("stall_cnt", k, stall_cnt[k], mstall[k]);
      chk("flush_cnt", k, flush_cnt[k], mflush[k]);
    end
    chk("stall_sat", 1, stall_cnt[1], 16'hFFFF);
    chk("flush_one", 1, flush_cnt[1], 16'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic elastic pipeline stage register, the parametrised successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload plus a control-field vector, with a valid/ready handshake, synchronous flush and optional 2-entry skid buffering.
- Drops in between any two core stages.
- Bubbles always present all-zero control, so a drained or flushed slot can never write the register file or memory.

Parameters:
- DATA_W, 96: payload width in bits (e.g. EX/MEM: target, ALU result, store data).
- CTRL_W, 12: control-field width (rd, funct3, RegWrite, MemRead, ...); zeroed in bubbles.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous kill of all held entries (branch mispredict / trap).
- in_valid, input, 1: upstream holds a valid entry.
- in_ready, output, 1: stage accepts an entry this cycle.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control vector.
- out_valid, output, 1: stage presents a valid entry.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, DATA_W: payload of the head entry.
- out_ctrl, output, CTRL_W: control of the head entry; 0 when out_valid = 0.

Behaviour:
- Reset: rst_n low sets, asynchronously, out_valid = 0, out_data = 0, out_ctrl = 0, skid entry cleared and state EMPTY. in_ready = 1 for SKID = 1.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Payload and control are stable while out_valid & !out_ready. Latency is 1 cycle from in_fire to out_valid.
- SKID = 1 state machine (main register M, skid register S):
  - EMPTY: in_fire -> M <= in, go to FULL.
  - FULL: in_fire & out_fire -> M <= in, stay FULL.
  - FULL: in_fire & !out_fire -> S <= in, go to SKID.
  - FULL: !in_fire & out_fire -> go to EMPTY, M ctrl <= 0.
  - SKID: in_ready = 0. out_fire -> M <= S, S ctrl <= 0, go to FULL.
- SKID = 1 outputs: in_ready = (state != SKID), registered, with no combinational path from out_ready.
- SKID = 0: single register M. in_ready = out_ready | !out_valid (combinational).
  - in_fire -> M <= in, out_valid <= 1.
  - out_fire & !in_fire -> out_valid <= 0, M ctrl <= 0.
- Flush: has priority over every other event in the same cycle.
  - Next state is EMPTY, out_valid <= 0, all ctrl registers <= 0.
  - Data registers hold their values.
  - An in_fire coinciding with flush is discarded.
  - out_fire in the flush cycle still completes, since downstream samples the current head.
- Back-to-back: with out_ready held at 1, one entry per cycle is sustained in both SKID modes.
- Ordering: strictly FIFO; S never overtakes M.
- Reset mid-operation: all entries lost immediately and no partial outputs occur; in_ready returns to 1 in the cycle following deassertion.
- Data registers are never written unless in_fire or the S->M transfer occurs (power/debug visibility).

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, two extra outputs exist:
  - stall_cnt [15:0]: counts cycles with out_valid & !out_ready; saturates at 16'hFFFF.
  - flush_cnt [15:0]: counts cycles with flush = 1 while at least one entry is valid; saturates at 16'hFFFF.
  - Both counters reset to 0 on rst_n low.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - the state typedef pipe_state_t {EMPTY = 2'b00, FULL = 2'b01, SKID = 2'b10};
  - EX/MEM control bit indices: CTRL_REGWRITE = 0, CTRL_MEMREAD = 1, CTRL_MEMWRITE = 2, CTRL_MEMTOREG = 3, CTRL_BRANCH = 4, CTRL_ZERO = 5, CTRL_RD_LSB = 6 (5 bits);
  - default width constants.
- Sub-module pipe_stage_stats holds the saturating counters, instantiated only under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset: assert rst_n = 0 mid-clock with M and S full -> out_valid = 0 and out_ctrl = 0 immediately; after release, in_ready = 1.
- Streaming (SKID = 1, out_ready = 1): push 0x1..0x8 on consecutive cycles -> out_data shows 0x1..0x8 one cycle later, with no gaps and in_ready constantly 1.
- Backpressure:
  - Setup: push A = 0xA, then B = 0xB, with out_ready = 0.
  - Expected: state SKID, in_ready = 0, out_data = 0xA held.
  - Release: set out_ready = 1 -> A, then B, on consecutive cycles, followed by out_valid = 0 and out_ctrl = 0.
- Flush: in state SKID with ctrl = 12'h03F, assert flush together with in_valid (C = 0xC) -> next cycle out_valid = 0, out_ctrl = 0, and C is never output.
- SKID = 0 variant: out_ready = 0 while full -> in_ready = 0 combinationally; toggling out_ready to 1 raises in_ready in the same cycle, and the new entry replaces the old one on that edge.
- Stats (with PIPE_STAGE_STATS_EN): hold out_ready = 0 for 70000 cycles with a valid entry -> stall_cnt = 16'hFFFF; one flush while valid -> flush_cnt = 1.
